// File: rtl/nor_red_pipe.sv
// rtl/nor_red_pipe.sv - pipelined N-input OR/AND/XOR reduction with optional inversion and valid/ready handshake; optional hit counter under NOR_RED_STATS_EN
`timescale 1ns/1ps

module nor_red_pipe #(
    parameter int N           = 8,
    parameter int LVL_PER_STG = 1
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         IN_VLD,
    output logic         IN_RDY,
    input  logic [N-1:0] IN,
    input  logic [1:0]   MODE,
    input  logic         INV,
    output logic         OUT_VLD,
    input  logic         OUT_RDY,
`ifdef NOR_RED_STATS_EN
    input  logic         CNT_CLR,
    output logic [15:0]  HIT_CNT,
`endif
    output logic         OUT0
);

    // Tree geometry: L levels over a power-of-two padded vector, split into S register stages
    localparam int L  = $clog2(N);
    localparam int P  = 1 << L;
    localparam int S  = (L + LVL_PER_STG - 1) / LVL_PER_STG;
    localparam int SM = (S > 1) ? S - 1 : 1;

    localparam logic [1:0] M_AND = 2'b01;
    localparam logic [1:0] M_XOR = 2'b10;

    // Apply nlev pairwise combine levels; the partial result is packed into the low bits
    function automatic logic [P-1:0] red_levels(input logic [P-1:0] v_in,
                                                input logic [1:0]   mode,
                                                input int           nlev);
        logic [P-1:0] v;
        v = v_in;
        for (int lv = 0; lv < L; lv++) begin
            if (lv < nlev) begin
                for (int j = 0; j < P / 2; j++) begin
                    case (mode)
                        M_AND:   v[j] = v[2*j] & v[2*j+1];
                        M_XOR:   v[j] = v[2*j] ^ v[2*j+1];
                        default: v[j] = v[2*j] | v[2*j+1];
                    endcase
                end
            end
        end
        return v;
    endfunction

    // Final levels plus the output inversion, which only the last stage applies
    function automatic logic red_bit(input logic [P-1:0] v_in,
                                     input logic [1:0]   mode,
                                     input int           nlev,
                                     input logic         inv);
        logic [P-1:0] v;
        v = red_levels(v_in, mode, nlev);
        return v[0] ^ inv;
    endfunction

    logic [P-1:0] w_pad;
    logic [S-1:0] w_adv;
    logic [S-1:0] w_vin;
    logic [S-1:0] r_vld;
    logic         r_out;
    logic [P-1:0] r_data [SM];
    logic [1:0]   r_mode [SM];
    logic         r_inv  [SM];

    // Pad missing leaves with the identity of the selected function (1 for AND, else 0)
    always_comb begin
        w_pad        = (MODE == M_AND) ? {P{1'b1}} : {P{1'b0}};
        w_pad[N-1:0] = IN;
    end

    // A stage advances when empty or when the next stage advances; bubbles collapse
    always_comb begin
        w_adv        = '0;
        w_adv[S-1]   = !r_vld[S-1] || OUT_RDY;
        for (int i = S - 2; i >= 0; i--) begin
            w_adv[i] = !r_vld[i] || w_adv[i+1];
        end
    end

    // Incoming valid for each stage: IN_VLD for stage 0, previous stage valid otherwise
    if (S > 1) begin : g_vin_chain
        assign w_vin = {r_vld[S-2:0], IN_VLD};
    end else begin : g_vin_single
        assign w_vin = IN_VLD;
    end

    // Stage valids: cleared asynchronously so in-flight words are dropped on reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_vld <= '0;
        end else begin
            for (int i = 0; i < S; i++) begin
                if (w_adv[i]) begin
                    r_vld[i] <= w_vin[i];
                end
            end
        end
    end

    for (genvar i = 0; i < S - 1; i++) begin : g_mid
        localparam int NL = ((L - i * LVL_PER_STG) < LVL_PER_STG) ?
                            (L - i * LVL_PER_STG) : LVL_PER_STG;
        logic [P-1:0] w_src;
        logic [1:0]   w_msrc;
        logic         w_isrc;

        if (i == 0) begin : g_first
            assign w_src  = w_pad;
            assign w_msrc = MODE;
            assign w_isrc = INV;
        end else begin : g_inner
            assign w_src  = r_data[i-1];
            assign w_msrc = r_mode[i-1];
            assign w_isrc = r_inv[i-1];
        end

        // Capture the partial reduction along with the mode/inversion that belong to this word
        always_ff @(posedge CLK) begin
            if (w_adv[i] && w_vin[i]) begin
                r_data[i] <= red_levels(w_src, w_msrc, NL);
                r_mode[i] <= w_msrc;
                r_inv[i]  <= w_isrc;
            end
        end
    end

    localparam int NLF = L - (S - 1) * LVL_PER_STG;
    logic [P-1:0] w_fsrc;
    logic [1:0]   w_fmode;
    logic         w_finv;
    logic         w_fres;

    if (S == 1) begin : g_final_direct
        assign w_fsrc  = w_pad;
        assign w_fmode = MODE;
        assign w_finv  = INV;
    end else begin : g_final_piped
        assign w_fsrc  = r_data[S-2];
        assign w_fmode = r_mode[S-2];
        assign w_finv  = r_inv[S-2];
    end

    assign w_fres = red_bit(w_fsrc, w_fmode, NLF, w_finv);

    // Final result register; holds while the output is stalled
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_out <= 1'b0;
        end else if (w_adv[S-1] && w_vin[S-1]) begin
            r_out <= w_fres;
        end
    end

    assign IN_RDY  = w_adv[0];
    assign OUT_VLD = r_vld[S-1];
    // Gate with valid so undefined data never shows on OUT0 while idle
    assign OUT0    = r_vld[S-1] & r_out;

`ifdef NOR_RED_STATS_EN
    logic [15:0] r_hit_cnt;

    // Count accepted results equal to 1; clear has priority and the count saturates
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_hit_cnt <= 16'h0000;
        end else if (CNT_CLR) begin
            r_hit_cnt <= 16'h0000;
        end else if (OUT_VLD && OUT_RDY && OUT0 && (r_hit_cnt != 16'hFFFF)) begin
            r_hit_cnt <= r_hit_cnt + 16'h0001;
        end
    end

    assign HIT_CNT = r_hit_cnt;
`endif

endmodule

// File: tb/tb_nor_red_pipe.sv
// tb/tb_nor_red_pipe.sv - scoreboard bench for nor_red_pipe (N=8 and N=5, S=3)
`timescale 1ns/1ps

module tb_nor_red_pipe;

    localparam int S = 3;
    localparam logic [1:0] M_OR  = 2'b00;
    localparam logic [1:0] M_AND = 2'b01;
    localparam logic [1:0] M_XOR = 2'b10;
    localparam logic [1:0] M_RSV = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_vld = 1'b0;
    logic       out_rdy = 1'b1;
    logic       inv = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] din = 8'h00;
    logic       rdy8, rdy5, vld8, vld5, o8, o5;
`ifdef NOR_RED_STATS_EN
    logic        cnt_clr = 1'b0;
    logic [15:0] hit8, hit5;
`endif

    always #5 clk = ~clk;

    nor_red_pipe #(.N(8), .LVL_PER_STG(1)) u_dut8 (
        .CLK(clk), .RST_N(rst_n), .IN_VLD(in_vld), .IN_RDY(rdy8), .IN(din),
        .MODE(mode), .INV(inv), .OUT_VLD(vld8), .OUT_RDY(out_rdy),
`ifdef NOR_RED_STATS_EN
        .CNT_CLR(cnt_clr), .HIT_CNT(hit8),
`endif
        .OUT0(o8)
    );

    nor_red_pipe #(.N(5), .LVL_PER_STG(1)) u_dut5 (
        .CLK(clk), .RST_N(rst_n), .IN_VLD(in_vld), .IN_RDY(rdy5), .IN(din[4:0]),
        .MODE(mode), .INV(inv), .OUT_VLD(vld5), .OUT_RDY(out_rdy),
`ifdef NOR_RED_STATS_EN
        .CNT_CLR(cnt_clr), .HIT_CNT(hit5),
`endif
        .OUT0(o5)
    );

    typedef struct {
        logic e8;
        logic e5;
        int   due;
        bit   chk;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   dd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output transfer pops the oldest expected result
    always @(negedge clk) begin
        if (rst_n && (vld8 || vld5) && out_rdy) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_vld8", {31'd0, vld8}, 32'd1);
                check("out_vld5", {31'd0, vld5}, 32'd1);
                check("out0_n8", {31'd0, o8}, {31'd0, e.e8});
                check("out0_n5", {31'd0, o5}, {31'd0, e.e5});
                if (e.chk) check("latency", cyc, e.due);
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [1:0] m, input logic iv,
                        input logic e8, input logic e5, input bit chk, output int due);
        exp_t e;
        int   k;
        in_vld = 1'b1;
        din    = d;
        mode   = m;
        inv    = iv;
        due    = 0;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rdy8) break;
            @(posedge clk);
            #1;
        end
        if (k == 50) begin
            check("send_timeout", 32'd1, 32'd0);
        end else begin
            e.e8 = e8; e.e5 = e5; e.due = cyc + S; e.chk = chk;
            due  = e.due;
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        in_vld = 1'b0;
        din    = 'x;
        mode   = M_OR;
        inv    = 1'b0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        if (k == 50) check("drain_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_rdy", {31'd0, rdy8}, 32'd1);
        check("rst_out_vld", {31'd0, vld8}, 32'd0);
        check("rst_out0", {31'd0, o8}, 32'd0);
        @(posedge clk);
        #1;

        // NOR: all zeros -> 1, one bit set -> 0, back to back
        send(8'h00, M_OR, 1'b1, 1'b1, 1'b1, 1'b1, dd);
        send(8'h10, M_OR, 1'b1, 1'b0, 1'b0, 1'b1, dd);
        idle();
        drain();

        // AND padding on N=5 and mixed per-word modes
        send(8'h1F, M_AND, 1'b0, 1'b0, 1'b1, 1'b1, dd);
        send(8'h0F, M_AND, 1'b0, 1'b0, 1'b0, 1'b1, dd);
        send(8'h07, M_XOR, 1'b0, 1'b1, 1'b1, 1'b1, dd);
        send(8'h07, M_XOR, 1'b1, 1'b0, 1'b0, 1'b1, dd);
        send(8'hFF, M_AND, 1'b0, 1'b1, 1'b1, 1'b1, dd);
        send(8'h00, M_OR,  1'b0, 1'b0, 1'b0, 1'b1, dd);
        send(8'h20, M_RSV, 1'b0, 1'b1, 1'b0, 1'b1, dd);
        send(8'hE0, M_XOR, 1'b0, 1'b1, 1'b0, 1'b1, dd);
        idle();
        drain();

        // Backpressure: three words fill the pipe, the rest wait
        out_rdy = 1'b0;
        send(8'h01, M_OR,  1'b0, 1'b1, 1'b1, 1'b0, dd);
        send(8'h00, M_OR,  1'b0, 1'b0, 1'b0, 1'b0, dd);
        send(8'h80, M_OR,  1'b0, 1'b1, 1'b0, 1'b0, dd);
        in_vld = 1'b1; din = 8'h00; mode = M_OR; inv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_in_rdy", {31'd0, rdy8}, 32'd0);
            check("stall_out_vld", {31'd0, vld8}, 32'd1);
            check("stall_out0_n8", {31'd0, o8}, {31'd0, sb[0].e8});
            check("stall_out0_n5", {31'd0, o5}, {31'd0, sb[0].e5});
            @(posedge clk);
            #1;
        end
        out_rdy = 1'b1;
        send(8'h00, M_OR,  1'b1, 1'b1, 1'b1, 1'b0, dd);
        send(8'h03, M_XOR, 1'b0, 1'b0, 1'b0, 1'b0, dd);
        idle();
        drain();

        // Reset with two words in flight: both must vanish
        send(8'hFF, M_OR, 1'b0, 1'b1, 1'b1, 1'b1, dd);
        send(8'hFF, M_OR, 1'b0, 1'b1, 1'b1, 1'b1, dd);
        idle();
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_out_vld8", {31'd0, vld8}, 32'd0);
        check("async_rst_out_vld5", {31'd0, vld5}, 32'd0);
        check("async_rst_out0", {31'd0, o8}, 32'd0);
        sb.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_idle", {31'd0, vld8}, 32'd0);
        end
        @(posedge clk);
        #1;
        send(8'h40, M_XOR, 1'b1, 1'b0, 1'b1, 1'b1, dd);
        idle();
        drain();

`ifdef NOR_RED_STATS_EN
        begin
            int d0;
            int k;
            cnt_clr = 1'b1;
            @(posedge clk);
            #1 cnt_clr = 1'b0;
            check("hit_clr", {16'd0, hit8}, 32'd0);
            send(8'h00, M_OR,  1'b1, 1'b1, 1'b1, 1'b1, dd);
            send(8'hFF, M_AND, 1'b0, 1'b1, 1'b1, 1'b1, dd);
            send(8'h01, M_OR,  1'b1, 1'b0, 1'b0, 1'b1, dd);
            send(8'h01, M_OR,  1'b0, 1'b1, 1'b1, 1'b1, dd);
            idle();
            drain();
            check("hit_cnt_n8", {16'd0, hit8}, 32'd3);
            check("hit_cnt_n5", {16'd0, hit5}, 32'd3);
            send(8'h00, M_OR,  1'b1, 1'b1, 1'b1, 1'b1, d0);
            send(8'hFF, M_AND, 1'b0, 1'b1, 1'b1, 1'b1, dd);
            send(8'h01, M_OR,  1'b1, 1'b0, 1'b0, 1'b1, dd);
            send(8'h01, M_OR,  1'b0, 1'b1, 1'b1, 1'b1, dd);
            idle();
            for (k = 0; k < 20; k++) begin
                @(negedge clk);
                if (cyc == d0 + 3) break;
            end
            if (k == 20) check("clr_window_timeout", 32'd1, 32'd0);
            cnt_clr = 1'b1;
            @(posedge clk);
            #1 cnt_clr = 1'b0;
            check("hit_clr_wins", {16'd0, hit8}, 32'd0);
            drain();
        end
`endif

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
